// File: rtl/mutex_arbiter_n_if.sv
// Request/grant bundle between N masters and the mutex arbiter.
// The master side drives req; the arbiter (slave) side drives the grant outputs.
interface mutex_arbiter_n_if #(parameter int N = 4);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           tout;

  modport master (output req, input gnt, gnt_id, busy, tout);
  modport slave  (input req, output gnt, gnt_id, busy, tout);
endinterface

// File: rtl/mutex_arbiter_n.sv
// N-channel round-robin mutex arbiter with a break-before-make gap and optional hold timeout.
// Define MUTEX_ARB_SYNC_EN to pass each req bit through a 2-flop synchroniser first.
module mutex_arbiter_n #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  mutex_arbiter_n_if.slave bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [CW-1:0] CNT_SAT  = CW'(HOLD_MAX);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   req_s, elig, lock, win_oh;
  logic [IDW-1:0] ptr, win, win_nxt, ptr_nxt;
  logic [IDW:0]   idx;
  logic [CW-1:0]  cnt;
  logic           any_elig, hit, revoke, tout_q;

`ifdef MUTEX_ARB_SYNC_EN
  logic [N-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.req;
      sync2 <= sync1;
    end
  assign req_s = sync2;
`else
  assign req_s = bus.req;
`endif

  // A timed-out channel stays locked out until it drops its request.
  assign elig   = req_s & ~lock;
  assign win_oh = {{(N-1){1'b0}}, 1'b1} << win;
  assign hit    = (HOLD_MAX > 0) && (cnt == CNT_LAST);
  assign revoke = (state == GRANT) && req_s[win] && hit;

  // First eligible channel at or after ptr, wrapping.
  always_comb begin
    any_elig = 1'b0;
    win_nxt  = ptr;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
      if (!any_elig && elig[idx[IDW-1:0]]) begin
        any_elig = 1'b1;
        win_nxt  = idx[IDW-1:0];
      end
    end
  end

  assign ptr_nxt = (win_nxt == IDW'(N - 1)) ? '0 : win_nxt + 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_elig) state_nxt = GRANT;
      GRANT:   if (!req_s[win] || revoke) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt    = '0;
    bus.gnt_id = '0;
    bus.busy   = 1'b0;
    if (state == GRANT) begin
      bus.gnt    = win_oh;
      bus.gnt_id = win;
      bus.busy   = 1'b1;
    end
  end
  assign bus.tout = tout_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr    <= '0;
      win    <= '0;
      lock   <= '0;
      cnt    <= '0;
      tout_q <= 1'b0;
    end else begin
      tout_q <= revoke;
      lock   <= (lock & req_s) | (revoke ? win_oh : '0);
      if (state == IDLE && any_elig) begin
        win <= win_nxt;
        ptr <= ptr_nxt;
        cnt <= '0;
      end else if (state == GRANT && cnt != CNT_SAT) begin
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: doc/mutex_arbiter_n.md
# mutex_arbiter_n

- Synchronous N-channel mutual-exclusion arbiter; parametrised successor of the two-input cross-coupled mutex cell.
- Grants exactly one requester at a time, holds the grant for as long as that requester keeps its request asserted, and rotates priority round-robin.
- Inserts a guaranteed break-before-make idle cycle between grants.
- An optional hold-timeout revokes a grant that is held too long.
- Sits between multiple masters and one shared resource (bus, memory port, log buffer).

## Interface

Parameters:
- N, 4, number of requesting channels (2..16).
- HOLD_MAX, 0, maximum grant duration in cycles; 0 disables the timeout.
- IDW, $clog2(N), width of GNT_ID (derived, not overridden).

Ports:
- CLK  input  1  single clock; all logic on the rising edge.
- RST_N  input  1  reset, asynchronous and active-low.
- REQ  input  N  request per channel; level-sensitive, held high while the resource is wanted.
- GNT  output  N  one-hot grant; all zero when idle.
- GNT_ID  output  IDW  binary index of the granted channel; 0 when idle.
- BUSY  output  1  high while any grant is active.
- TOUT  output  1  one-cycle pulse when a grant is revoked by timeout.

## Operation

- **State machine** (IDLE, GRANT, GAP):
  - IDLE: if any eligible REQ bit is sampled high, pick the winner, go to GRANT; else stay.
  - GRANT: if REQ[winner] is sampled low, go to GAP. If HOLD_MAX>0 and the hold counter equals HOLD_MAX-1 while REQ[winner] is still high, revoke the grant, pulse TOUT, set LOCK[winner], go to GAP.
  - GAP: always return to IDLE after one cycle. No grant is issued in GAP.
- **Winner selection:**
  - Round-robin from pointer PTR (0..N-1): the first eligible channel at or after PTR, wrapping from N-1 to 0.
  - On grant, PTR becomes (winner+1) mod N.
- **Eligibility:**
  - REQ[i] high and LOCK[i] clear.
  - LOCK[i] clears in any cycle where REQ[i] is sampled low. A timed-out channel must drop and re-raise its request.
- **Hold counter:**
  - Width $clog2(HOLD_MAX+1).
  - Cleared on entry to GRANT; increments each cycle in GRANT; saturates, never wraps.
- **Invariants:**
  - GNT is never more than one-hot.
  - GNT never changes directly from one channel to another.
  - BUSY equals OR of GNT.
  - GNT_ID is consistent with GNT in the same cycle.

## Timing

- Reset (RST_N low, asynchronous):
  - Outputs: GNT=0, GNT_ID=0, BUSY=0, TOUT=0.
  - Internal state: state=IDLE, PTR=0, LOCK=0, counter=0.
- Reset asserted mid-grant clears GNT immediately, without waiting for a clock edge.
- Reset deassertion is synchronised externally. The first grant can occur on the first rising edge after RST_N is high.
- **Grant latency:** REQ high sampled at edge k in IDLE gives GNT high from edge k (registered output, visible in cycle k+1).
- **Release latency:** REQ low sampled at edge k in GRANT gives GNT low from edge k.
- **Next grant:** issued no earlier than edge k+2, so GNT is low for at least one full cycle.
- **Timeout:** GNT stays high for exactly HOLD_MAX cycles. TOUT is high in the cycle after GNT falls (registered with the revoke).
- **Simultaneous events:**
  - REQ drop on the same edge the timeout would fire: treat as a normal release. TOUT stays 0 and LOCK is not set.
  - Multiple REQ rising on the same edge: round-robin from PTR decides.
  - REQ of a non-granted channel toggling during GRANT or GAP: ignored until IDLE.

## Configuration

- **Macro:** `MUTEX_ARB_SYNC_EN`.
- **Defined:**
  - Each REQ bit passes through a 2-flop synchroniser (reset to 0) before the state machine, so REQ may be asynchronous to CLK.
  - Grant and release latencies each increase by 2 cycles: grant at edge k+2, release at edge k+2.
- **Undefined:**
  - REQ is used directly. It must be synchronous to CLK.
  - Latencies are as stated in Timing.

## Test plan

Defaults unless stated: N=4, HOLD_MAX=0, macro undefined.

- **Reset:** hold RST_N=0 with REQ=4'b1111, then pulse RST_N low mid-grant -> GNT=0, GNT_ID=0, BUSY=0, TOUT=0 immediately in both cases; PTR restarts at 0, so the first grant after release is GNT=4'b0001.
- **Single request:** REQ=4'b0100 at edge 1 -> GNT=4'b0100, GNT_ID=2 from edge 1. REQ dropped at edge 5 -> GNT=0 from edge 5, BUSY=0.
- **Round-robin:** REQ=4'b1111 held, each grantee drops its request for one cycle after 3 granted cycles -> grant order 0,1,2,3,0, with one idle cycle between consecutive grants.
- **Break-before-make:** REQ=4'b0011, channel 0 releases at edge 4 -> GNT=0 at edge 4, GNT=4'b0010 at edge 6. GNT never equals 4'b0011.
- **Timeout (HOLD_MAX=8):**
  - REQ=4'b0001 held -> GNT high for exactly 8 cycles, then TOUT single pulse, GNT=0.
  - Channel 0 not regranted while REQ[0] stays high.
  - Drop REQ[0] one cycle and re-raise it -> regranted.
  - REQ drop on the timeout edge -> no TOUT.
- **Synchroniser (macro defined):** REQ=4'b1000 at edge 1 -> GNT=4'b1000 at edge 3. Release at edge 10 -> GNT=0 at edge 12.
